mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Arbitrates the runtime SRAM parallel bus between two requesters: the core (port C) and the JTAG port (port J).
Sequences each access as a fixed-length, multi-cycle SRAM cycle, drives address, write, enable and data-out-enable, and captures read data.
Sits between the requesters and the memory controller/pin drivers. Replaces the current JTAG-only bus ownership.

Parameters:
WAIT_CYCLES, 2, cycles o_memEn is held per access; legal 1..15.
ADDR_W, 16, address width.
DATA_W, 16, data width.

Ports:
i_clk  in  1  system clock.
i_rst  in  1  asynchronous, active-high reset.
i_coreReq  in  1  core access request; held until o_coreAck.
i_coreWr  in  1  core write (1) / read (0); stable while i_coreReq=1.
i_coreAddr  in  ADDR_W  core address; stable while i_coreReq=1.
i_coreData  in  DATA_W  core write data; stable while i_coreReq=1.
o_coreAck  out  1  one-cycle completion pulse to core.
i_coreHold  in  1  core paused; while 1, core requests are not granted.
i_jtagReq, i_jtagWr, i_jtagAddr, i_jtagData  in  1/1/ADDR_W/DATA_W  JTAG equivalents of the core inputs.
o_jtagAck  out  1  one-cycle completion pulse to JTAG.
o_rdData  out  DATA_W  registered read data, shared by both ports; valid with ack.
o_memAddr  out  ADDR_W  SRAM address.
o_memWr  out  1  SRAM write strobe.
o_memEn  out  1  SRAM enable.
o_memDataOut  out  DATA_W  write data to tristate driver.
o_memDataOe  out  1  tristate output enable.
i_memDataIn  in  DATA_W  SRAM data bus (read).
o_busy  out  1  1 in ACCESS or DONE.

Behaviour:
- All outputs are registered.
- Reset (async, i_rst=1):
  - state=IDLE, count=0, lastGrant=J.
  - All outputs 0.
  - Reset mid-access aborts immediately, with no ack and the bus released in the same cycle.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - eligC = i_coreReq & ~i_coreHold.
  - eligJ = i_jtagReq.
  - Neither eligible: stay in IDLE.
  - One eligible: grant that port.
  - Both eligible: grant the port opposite lastGrant (round robin). After reset, the core wins the first tie.
  - On grant, latch owner, wr, addr and data, and set lastGrant=owner, count=WAIT_CYCLES-1. Go to ACCESS.
- ACCESS (exactly WAIT_CYCLES cycles):
  - o_memEn=1.
  - o_memAddr = latched addr.
  - o_memWr = latched wr.
  - o_memDataOe = latched wr.
  - o_memDataOut = latched data.
  - count decrements each cycle. At count=0:
    - read: capture i_memDataIn into o_rdData at that edge.
    - go to DONE.
- DONE (1 cycle, bus turnaround):
  - o_memEn=0, o_memWr=0, o_memDataOe=0.
  - o_memAddr holds its value.
  - Owner's ack=1; the other port's ack=0.
  - o_rdData holds the captured value for a read; it is unchanged on a write.
  - Next state is IDLE.
- Latency:
  - Request sampled in IDLE at edge N.
  - ACCESS covers cycles N+1..N+WAIT_CYCLES.
  - Ack appears in cycle N+WAIT_CYCLES+1.
  - Minimum spacing between grants is WAIT_CYCLES+2 cycles.
- Requester protocol:
  - Drop req in the cycle after ack is seen.
  - If req is still high in IDLE, it is treated as a new request.
  - Inputs that change while req=1 before grant are undefined. After grant, input changes are ignored because values are latched.
- i_coreHold:
  - Evaluated only in IDLE.
  - Rising during a core ACCESS does not abort it; the access completes and acks normally.
- A non-owner request asserted during ACCESS/DONE waits; it is evaluated in the next IDLE.
- o_memAddr, o_memDataOut and o_rdData are never cleared except by reset.
- o_memDataOe and o_memWr are never 1 outside ACCESS.
- The count register is 4 bits; WAIT_CYCLES=1 gives a single ACCESS cycle.

Test Plan:
1. WAIT_CYCLES=2; core read addr 0x0010; memory returns 0xBEEF.
   -> o_memEn=1 for 2 cycles with o_memAddr=0x0010, o_memWr=0, o_memDataOe=0.
   -> o_coreAck=1 exactly 3 cycles after request sampled, with o_rdData=0xBEEF; o_jtagAck stays 0.
2. JTAG write addr 0xFFFF, data 0x1234.
   -> o_memWr=1, o_memDataOe=1, o_memDataOut=0x1234 for 2 cycles.
   -> Then DONE with Oe=0 and o_jtagAck pulse.
   -> o_rdData unchanged from the previous value.
3. Both ports request at the same edge, directly after reset.
   -> Core is granted first, then JTAG.
   -> Repeat with both held continuously: grants alternate C,J,C,J, with acks spaced 4 cycles apart.
4. i_coreHold=1 with both requesting.
   -> Only JTAG is granted repeatedly.
   -> Set i_coreHold=0 in the middle of a JTAG ACCESS: core is granted at the next IDLE.
5. Assert i_rst in the second ACCESS cycle of a core write.
   -> All outputs are 0 the same cycle; no ack is produced.
   -> After release, a fresh JTAG request completes normally.
6. WAIT_CYCLES=1; back-to-back core reads to 0x0001 and 0x0002 returning 0x00AA and 0x00BB.
   -> Acks are 3 cycles apart with o_rdData=0x00AA then 0x00BB.
   -> o_memEn drops to 0 in every DONE cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port (core/JTAG) round-robin arbiter and fixed-length SRAM cycle sequencer
module mem_bus_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_coreReq,
    input  logic              i_coreWr,
    input  logic [ADDR_W-1:0] i_coreAddr,
    input  logic [DATA_W-1:0] i_coreData,
    output logic              o_coreAck,
    input  logic              i_coreHold,
    input  logic              i_jtagReq,
    input  logic              i_jtagWr,
    input  logic [ADDR_W-1:0] i_jtagAddr,
    input  logic [DATA_W-1:0] i_jtagData,
    output logic              o_jtagAck,
    output logic [DATA_W-1:0] o_rdData,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic              o_memWr,
    output logic              o_memEn,
    output logic [DATA_W-1:0] o_memDataOut,
    output logic              o_memDataOe,
    input  logic [DATA_W-1:0] i_memDataIn,
    output logic              o_busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_J = 1'b1;

    localparam logic [3:0] COUNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] count;
    logic       owner;
    logic       lastGrant;
    logic       latWr;

    logic eligC;
    logic eligJ;
    logic pickJ;
    logic grantWr;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        eligC   = i_coreReq & ~i_coreHold;
        eligJ   = i_jtagReq;
        pickJ   = eligJ & (~eligC | (lastGrant == PORT_C));
        grantWr = pickJ ? i_jtagWr : i_coreWr;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            count        <= 4'd0;
            owner        <= PORT_C;
            lastGrant    <= PORT_J;
            latWr        <= 1'b0;
            o_coreAck    <= 1'b0;
            o_jtagAck    <= 1'b0;
            o_rdData     <= '0;
            o_memAddr    <= '0;
            o_memWr      <= 1'b0;
            o_memEn      <= 1'b0;
            o_memDataOut <= '0;
            o_memDataOe  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_coreAck <= 1'b0;
            o_jtagAck <= 1'b0;
            case (state)
                IDLE: begin
                    if (eligC || eligJ) begin
                        owner        <= pickJ;
                        lastGrant    <= pickJ;
                        latWr        <= grantWr;
                        o_memAddr    <= pickJ ? i_jtagAddr : i_coreAddr;
                        o_memDataOut <= pickJ ? i_jtagData : i_coreData;
                        o_memWr      <= grantWr;
                        o_memDataOe  <= grantWr;
                        o_memEn      <= 1'b1;
                        o_busy       <= 1'b1;
                        count        <= COUNT_INIT;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count == 4'd0) begin
                        if (!latWr) begin
                            o_rdData <= i_memDataIn;
                        end
                        o_memEn     <= 1'b0;
                        o_memWr     <= 1'b0;
                        o_memDataOe <= 1'b0;
                        o_coreAck   <= (owner == PORT_C);
                        o_jtagAck   <= (owner == PORT_J);
                        state       <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coreReq = 1'b0;
    logic        coreWr = 1'b0;
    logic [15:0] coreAddr = 16'h0;
    logic [15:0] coreData = 16'h0;
    logic        coreHold = 1'b0;
    logic        jtagReq = 1'b0;
    logic        jtagWr = 1'b0;
    logic [15:0] jtagAddr = 16'h0;
    logic [15:0] jtagData = 16'h0;

    logic        coreAckA, jtagAckA, memWrA, memEnA, memDataOeA, busyA;
    logic [15:0] rdDataA, memAddrA, memDataOutA, memInA;
    logic        coreAckB, jtagAckB, memWrB, memEnB, memDataOeB, busyB;
    logic [15:0] rdDataB, memAddrB, memDataOutB, memInB;

    int chkCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rdModel(input logic [15:0] a);
        case (a)
            16'h0010: rdModel = 16'hBEEF;
            16'h0001: rdModel = 16'h00AA;
            16'h0002: rdModel = 16'h00BB;
            default:  rdModel = 16'h0000;
        endcase
    endfunction

    assign memInA = rdModel(memAddrA);
    assign memInB = rdModel(memAddrB);

    mem_bus_arbiter #(.WAIT_CYCLES(2), .ADDR_W(16), .DATA_W(16)) dutA (
        .i_clk(clk), .i_rst(rst),
        .i_coreReq(coreReq), .i_coreWr(coreWr), .i_coreAddr(coreAddr), .i_coreData(coreData),
        .o_coreAck(coreAckA), .i_coreHold(coreHold),
        .i_jtagReq(jtagReq), .i_jtagWr(jtagWr), .i_jtagAddr(jtagAddr), .i_jtagData(jtagData),
        .o_jtagAck(jtagAckA), .o_rdData(rdDataA), .o_memAddr(memAddrA), .o_memWr(memWrA),
        .o_memEn(memEnA), .o_memDataOut(memDataOutA), .o_memDataOe(memDataOeA),
        .i_memDataIn(memInA), .o_busy(busyA)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(1), .ADDR_W(16), .DATA_W(16)) dutB (
        .i_clk(clk), .i_rst(rst),
        .i_coreReq(coreReq), .i_coreWr(coreWr), .i_coreAddr(coreAddr), .i_coreData(coreData),
        .o_coreAck(coreAckB), .i_coreHold(coreHold),
        .i_jtagReq(jtagReq), .i_jtagWr(jtagWr), .i_jtagAddr(jtagAddr), .i_jtagData(jtagData),
        .o_jtagAck(jtagAckB), .o_rdData(rdDataB), .o_memAddr(memAddrB), .o_memWr(memWrB),
        .o_memEn(memEnB), .o_memDataOut(memDataOutB), .o_memDataOe(memDataOeB),
        .i_memDataIn(memInB), .o_busy(busyB)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    function automatic logic [63:0] outsA();
        outsA = {coreAckA, jtagAckA, rdDataA, memAddrA, memWrA, memEnA, memDataOutA, memDataOeA, busyA};
    endfunction

    initial begin
        // Reset state
        cyc(2);
        checkVal("reset_outs", outsA(), 64'h0);
        checkVal("reset_outsB", {coreAckB, jtagAckB, rdDataB, memAddrB, memEnB, busyB}, 64'h0);
        rst = 1'b0;

        // 1: core read 0x0010, memory returns 0xBEEF
        coreReq = 1'b1; coreWr = 1'b0; coreAddr = 16'h0010;
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            checkVal($sformatf("t1_en_%0d", k), memEnA, (k <= 2));
            checkVal($sformatf("t1_cack_%0d", k), coreAckA, (k == 3));
            checkVal($sformatf("t1_jack_%0d", k), jtagAckA, 1'b0);
            checkVal($sformatf("t1_wroe_%0d", k), {memWrA, memDataOeA}, 2'b00);
            checkVal($sformatf("t1_addr_%0d", k), memAddrA, 16'h0010);
            checkVal($sformatf("t1_busy_%0d", k), busyA, 1'b1);
        end
        checkVal("t1_rddata", rdDataA, 16'hBEEF);
        coreReq = 1'b0;
        cyc(1);
        checkVal("t1_idle", {coreAckA, busyA}, 2'b00);

        // 2: JTAG write 0xFFFF <- 0x1234
        jtagReq = 1'b1; jtagWr = 1'b1; jtagAddr = 16'hFFFF; jtagData = 16'h1234;
        for (int k = 1; k <= 2; k++) begin
            cyc(1);
            checkVal($sformatf("t2_acc_%0d", k), {memEnA, memWrA, memDataOeA}, 3'b111);
            checkVal($sformatf("t2_dout_%0d", k), memDataOutA, 16'h1234);
            checkVal($sformatf("t2_addr_%0d", k), memAddrA, 16'hFFFF);
        end
        cyc(1);
        checkVal("t2_done_ctl", {memEnA, memWrA, memDataOeA}, 3'b000);
        checkVal("t2_acks", {coreAckA, jtagAckA}, 2'b01);
        checkVal("t2_rddata_kept", rdDataA, 16'hBEEF);
        checkVal("t2_addr_hold", memAddrA, 16'hFFFF);
        jtagReq = 1'b0; jtagWr = 1'b0;
        cyc(1);

        // 3: simultaneous requests right after reset, then held continuously
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        coreReq = 1'b1; coreWr = 1'b0; coreAddr = 16'h0010;
        jtagReq = 1'b1; jtagWr = 1'b0; jtagAddr = 16'h0002;
        for (int k = 1; k <= 15; k++) begin
            cyc(1);
            checkVal($sformatf("t3_cack_%0d", k), coreAckA, (k == 3 || k == 11));
            checkVal($sformatf("t3_jack_%0d", k), jtagAckA, (k == 7 || k == 15));
            if (k == 3) checkVal("t3_rd_core", rdDataA, 16'hBEEF);
            if (k == 7) checkVal("t3_rd_jtag", rdDataA, 16'h00BB);
        end
        coreReq = 1'b0; jtagReq = 1'b0;
        cyc(2);
        checkVal("t3_idle", busyA, 1'b0);

        // 4: core held off; release hold during a JTAG access
        coreHold = 1'b1; coreReq = 1'b1; jtagReq = 1'b1;
        for (int m = 1; m <= 15; m++) begin
            cyc(1);
            if (m == 10) coreHold = 1'b0;
            checkVal($sformatf("t4_jack_%0d", m), jtagAckA, (m == 3 || m == 7 || m == 11));
            checkVal($sformatf("t4_cack_%0d", m), coreAckA, (m == 15));
        end
        coreReq = 1'b0; jtagReq = 1'b0;
        cyc(2);

        // 5: reset in the second ACCESS cycle of a core write
        coreReq = 1'b1; coreWr = 1'b1; coreAddr = 16'h0040; coreData = 16'h5555;
        cyc(1);
        checkVal("t5_acc1", {memEnA, memWrA, memDataOeA}, 3'b111);
        cyc(1);
        rst = 1'b1;
        coreReq = 1'b0; coreWr = 1'b0;
        #1;
        checkVal("t5_abort_outs", outsA(), 64'h0);
        cyc(1);
        checkVal("t5_no_ack", {coreAckA, jtagAckA}, 2'b00);
        rst = 1'b0;
        cyc(1);
        checkVal("t5_no_ack2", {coreAckA, jtagAckA, busyA}, 3'b000);
        jtagReq = 1'b1; jtagWr = 1'b0; jtagAddr = 16'h0001;
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            checkVal($sformatf("t5_jack_%0d", k), jtagAckA, (k == 3));
        end
        checkVal("t5_rddata", rdDataA, 16'h00AA);
        jtagReq = 1'b0;
        cyc(3);

        // 6: WAIT_CYCLES=1, back-to-back core reads
        coreReq = 1'b1; coreWr = 1'b0; coreAddr = 16'h0001;
        for (int q = 1; q <= 5; q++) begin
            cyc(1);
            checkVal($sformatf("t6_cack_%0d", q), coreAckB, (q == 2 || q == 5));
            checkVal($sformatf("t6_en_%0d", q), memEnB, (q == 1 || q == 4));
            if (q == 2) begin
                checkVal("t6_rd_first", rdDataB, 16'h00AA);
                coreAddr = 16'h0002;
            end
            if (q == 5) checkVal("t6_rd_second", rdDataB, 16'h00BB);
        end
        coreReq = 1'b0;
        cyc(2);
        checkVal("t6_idle", {busyB, memEnB, memWrB, memDataOeB}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", chkCount, errCount);
        $finish;
    end

endmodule
